led_panel_scheduler: RTL and testbench
======================================

# led_panel_scheduler

Shares the adapter's LED bank (three status LEDs plus eight-LED bar) between the bus-monitor requesters. Default adapter-identity display is heartbeat, mode and 4-bit id. Three prioritised requesters can claim the bar with a minimum hold time, and two trigger pulses are stretched onto the trigger LEDs. Sits between the monitor core and the adapter pins, replacing direct LED assignment.

## Interface
- CLK_DIV_W, 25, prescaler width; tick period = 2^CLK_DIV_W clocks; heartbeat = prescaler MSB
- HOLD_TICKS, 4, ticks a granted owner is protected from non-error preemption (1..15)
- STRETCH_TICKS, 2, ticks a trigger LED stays lit after a trigger edge (1..15)
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- mode  in  1  adapter mode strap
- id  in  4  adapter id strap
- req  in  3  panel requests: [2] error (highest priority), [1] activity, [0] user
- err_code, act_pat, usr_pat  in  8 each  live patterns for each requester
- trig  in  2  trigger levels; rising edges are stretched
- grant  out  3  one-hot current owner, 0 when idle
- led1  out  1  red heartbeat
- led2, led3  out  1  stretched trig[0], trig[1]
- ld  out  8  LED bar; ld[7] maps to pin ld1, ld[0] to pin ld8

## Operation
- Prescaler:
  - CLK_DIV_W-bit free-running counter.
  - tick is a 1-cycle pulse when the counter is all-ones.
  - Wraps silently.
- FSM states:
  - IDLE: grant=0; ld = {hb, 0, 0, mode, id}.
  - OWNED: ld = pattern of granted requester.
- IDLE -> OWNED: any req set. Grant the highest priority requester and load hold_cnt = HOLD_TICKS.
- OWNED, hold_cnt decrements on each tick and saturates at 0.
- OWNED transitions, evaluated in this order each cycle:
  - Owner drops its req: re-arbitrate immediately. Grant the highest pending requester, or go to IDLE if none.
  - req[2] set while owner is not error: error preempts regardless of hold_cnt and reloads hold.
  - hold_cnt==0 and another req is pending: rotate to the highest-priority pending requester other than the current owner. If the owner is error, it keeps the panel while req[2] is held. Reload hold.
  - Otherwise stay.
- led1:
  - IDLE and non-error owners: prescaler MSB.
  - Error owner: prescaler bit CLK_DIV_W-3 (4x blink rate).
- Trigger stretch, per channel:
  - Rising edge of trig (against the previous-cycle register) loads cnt = STRETCH_TICKS.
  - cnt decrements on tick.
  - LED = (cnt != 0).
  - Edge coincident with a tick: reload wins.
  - Retrigger while lit: reload.
- Width rules: hold and stretch counters are 4 bits; parameters above 15 are illegal (elaboration assertion).

## Timing
- All outputs are registered.
- Reset values: grant=0, ld=0, led1=0, led2=0, led3=0, prescaler=0, state IDLE, counters 0.
- First cycle after reset release: ld = {0, 0, 0, mode, id}.
- req change -> grant/ld update: 1 clock. Pattern change while owned -> ld: 1 clock.
- trig rising edge -> LED high: 1 clock.
- LED on-time after the edge: STRETCH_TICKS-1 to STRETCH_TICKS tick periods (first tick may be partial). Hold time has the same tolerance.
- Reset asserted mid-operation: everything returns to reset values asynchronously. Prescaler phase restarts from 0.
- grant and ld always change on the same edge; never one without the other.

## Configuration
- LED_PANEL_SYNC_EN defined:
  - 2-flop synchronisers on req, trig, mode and id (async sources).
  - All input-to-output latencies grow by 2 clocks.
- LED_PANEL_SYNC_EN undefined: inputs are assumed synchronous to clock and sampled directly.

## Structure
- led_panel_pkg:
  - owner encoding (OWN_NONE, OWN_USR, OWN_ACT, OWN_ERR)
  - FSM state enum (ST_IDLE, ST_OWNED)
  - counter width constant CNT_W=4
- Sub-module led_pulse_stretch: edge detect plus reload counter, instantiated twice for led2 and led3.
- Arbitration, prescaler and bar mux stay in the top module.

## Test plan
Bench uses CLK_DIV_W=4, HOLD_TICKS=2, STRETCH_TICKS=2, LED_PANEL_SYNC_EN off.
- Reset, mode=1, id=4'hA, no req -> grant=0; ld=8'b0001_1010 one clock after release, with ld[7] toggling every 8 clocks.
- req=3'b001, usr_pat=8'h5C -> next clock grant=001, ld=8'h5C; drop req -> next clock ld back to idle pattern.
- usr owns, then req[1] raised with act_pat=8'h33 -> grant stays 001 until hold_cnt reaches 0 (≤2 ticks = 32 clocks), then grant=010, ld=8'h33.
- act owns with hold fresh, req[2] raised with err_code=8'hE1 -> next clock grant=100, ld=8'hE1, led1 toggles every 2 clocks.
- trig[0] pulse one cycle -> led2 high next clock and low after 2 ticks; second pulse 20 clocks later extends on-time (reload).
- reset_n pulsed low while err owns with led2 lit -> grant=0, ld=0, led1–3=0 immediately; idle pattern 1 clock after release.

Source files
------------

// File: rtl/led_panel_pkg.sv
// led_panel_pkg: shared constants and helpers for the LED panel scheduler.
//   - Owner encoding (OWN_NONE, OWN_USR, OWN_ACT, OWN_ERR).
//   - FSM state constants (ST_IDLE, ST_OWNED).
//   - CNT_W: width of the hold and stretch tick counters.
//   - top_owner(): highest-priority requester in a request vector.
//   - owner_mask(): one-hot request/grant bit belonging to an owner.
package led_panel_pkg;

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_USR  = 2'd1;
    localparam logic [1:0] OWN_ACT  = 2'd2;
    localparam logic [1:0] OWN_ERR  = 2'd3;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    // req[2] error > req[1] activity > req[0] user
    function automatic logic [1:0] top_owner(input logic [2:0] r);
        if (r[2]) begin
            return OWN_ERR;
        end else if (r[1]) begin
            return OWN_ACT;
        end else if (r[0]) begin
            return OWN_USR;
        end
        return OWN_NONE;
    endfunction

    function automatic logic [2:0] owner_mask(input logic [1:0] o);
        case (o)
            OWN_USR: return 3'b001;
            OWN_ACT: return 3'b010;
            OWN_ERR: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/led_pulse_stretch.sv
// led_pulse_stretch: turns a rising edge on trig into an LED on-time of
// STRETCH_TICKS prescaler ticks (first tick may be partial).
// Ports:
//   clock, reset_n  system clock, async active-low reset
//   tick            1-cycle prescaler pulse
//   trig            trigger level (synchronous to clock)
//   led             registered stretched output
module led_pulse_stretch
    import led_panel_pkg::*;
#(
    parameter int unsigned STRETCH_TICKS = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic tick,
    input  logic trig,
    output logic led
);

    localparam logic [CNT_W-1:0] STRETCH_LD = CNT_W'(STRETCH_TICKS);

    logic             trig_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             led_q;

    // A new edge reloads even when it lands on a tick or the LED is already lit.
    always_comb begin
        cnt_d = cnt_q;
        if (trig && !trig_q) begin
            cnt_d = STRETCH_LD;
        end else if (tick && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            trig_q <= 1'b0;
            cnt_q  <= '0;
            led_q  <= 1'b0;
        end else begin
            trig_q <= trig;
            cnt_q  <= cnt_d;
            led_q  <= (cnt_d != '0);
        end
    end

    assign led = led_q;

endmodule

// File: rtl/led_panel_scheduler.sv
// led_panel_scheduler: shares the adapter LED bank between three prioritised
// requesters. Idle shows {heartbeat, 0, 0, mode, id}; a granted requester
// drives its live pattern onto the bar and is protected by a minimum hold.
// Two trigger inputs are stretched onto led2/led3.
// Optional build macro: LED_PANEL_SYNC_EN adds 2-flop synchronisers on
// req, trig, mode and id (latency +2 clocks).
// Ports:
//   clock, reset_n              system clock, async active-low reset
//   mode, id                    adapter straps shown in the idle pattern
//   req[2:0]                    [2] error, [1] activity, [0] user
//   err_code, act_pat, usr_pat  live bar patterns per requester
//   trig[1:0]                   trigger levels, rising edges stretched
//   grant[2:0]                  one-hot owner, 0 when idle
//   led1                        heartbeat (4x rate while error owns)
//   led2, led3                  stretched trig[0], trig[1]
//   ld[7:0]                     LED bar (ld[7] = pin ld1)
module led_panel_scheduler
    import led_panel_pkg::*;
#(
    parameter int unsigned CLK_DIV_W     = 25,
    parameter int unsigned HOLD_TICKS    = 4,
    parameter int unsigned STRETCH_TICKS = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       mode,
    input  logic [3:0] id,
    input  logic [2:0] req,
    input  logic [7:0] err_code,
    input  logic [7:0] act_pat,
    input  logic [7:0] usr_pat,
    input  logic [1:0] trig,
    output logic [2:0] grant,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic [7:0] ld
);

    if (HOLD_TICKS < 1 || HOLD_TICKS > 15) begin : g_bad_hold
        $error("HOLD_TICKS must be 1..15");
    end
    if (STRETCH_TICKS < 1 || STRETCH_TICKS > 15) begin : g_bad_stretch
        $error("STRETCH_TICKS must be 1..15");
    end
    if (CLK_DIV_W < 3) begin : g_bad_div
        $error("CLK_DIV_W must be at least 3");
    end

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_TICKS);

    logic [2:0] req_s;
    logic [1:0] trig_s;
    logic       mode_s;
    logic [3:0] id_s;

`ifdef LED_PANEL_SYNC_EN
    logic [9:0] sync1_q, sync2_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {req, trig, mode, id};
            sync2_q <= sync1_q;
        end
    end

    assign {req_s, trig_s, mode_s, id_s} = sync2_q;
`else
    assign {req_s, trig_s, mode_s, id_s} = {req, trig, mode, id};
`endif

    // Prescaler
    logic [CLK_DIV_W-1:0] div_q, div_d;
    logic                 tick;

    assign div_d = div_q + CLK_DIV_W'(1);
    assign tick  = &div_q;

    // Arbitration FSM
    logic [0:0]       state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [2:0]       own_mask, others;

    assign own_mask = owner_mask(owner_q);
    assign others   = req_s & ~own_mask;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        if (state_q == ST_IDLE) begin
            if (|req_s) begin
                state_d = ST_OWNED;
                owner_d = top_owner(req_s);
                hold_d  = HOLD_LD;
            end
        end else if ((req_s & own_mask) == 3'b000) begin
            // Owner released: hand over at once, hold does not apply.
            owner_d = top_owner(req_s);
            hold_d  = HOLD_LD;
            if (owner_d == OWN_NONE) begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        end else if (req_s[2] && owner_q != OWN_ERR) begin
            owner_d = OWN_ERR;
            hold_d  = HOLD_LD;
        end else if (hold_q == '0 && |others && owner_q != OWN_ERR) begin
            // Error never rotates away while req[2] is still held.
            owner_d = top_owner(others);
            hold_d  = HOLD_LD;
        end else if (tick && hold_q != '0) begin
            hold_d = hold_q - CNT_W'(1);
        end
    end

    // Outputs are registered from next-state values so grant and ld move together.
    logic [7:0] ld_d;
    logic       led1_d;

    always_comb begin
        case (owner_d)
            OWN_USR: ld_d = usr_pat;
            OWN_ACT: ld_d = act_pat;
            OWN_ERR: ld_d = err_code;
            default: ld_d = {div_d[CLK_DIV_W-1], 2'b00, mode_s, id_s};
        endcase
        led1_d = (owner_d == OWN_ERR) ? div_d[CLK_DIV_W-3] : div_d[CLK_DIV_W-1];
    end

    logic [2:0] grant_q;
    logic [7:0] ld_q;
    logic       led1_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= '0;
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
            hold_q  <= '0;
            grant_q <= 3'b000;
            ld_q    <= 8'h00;
            led1_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            state_q <= state_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            grant_q <= owner_mask(owner_d);
            ld_q    <= ld_d;
            led1_q  <= led1_d;
        end
    end

    assign grant = grant_q;
    assign ld    = ld_q;
    assign led1  = led1_q;

    led_pulse_stretch #(
        .STRETCH_TICKS(STRETCH_TICKS)
    ) u_stretch0 (
        .clock  (clock),
        .reset_n(reset_n),
        .tick   (tick),
        .trig   (trig_s[0]),
        .led    (led2)
    );

    led_pulse_stretch #(
        .STRETCH_TICKS(STRETCH_TICKS)
    ) u_stretch1 (
        .clock  (clock),
        .reset_n(reset_n),
        .tick   (tick),
        .trig   (trig_s[1]),
        .led    (led3)
    );

endmodule

// File: tb/tb_led_panel_scheduler.sv
module tb_led_panel_scheduler;

    logic       clock;
    logic       reset_n;
    logic       mode;
    logic [3:0] id;
    logic [2:0] req;
    logic [7:0] err_code, act_pat, usr_pat;
    logic [1:0] trig;
    logic [2:0] grant;
    logic       led1, led2, led3;
    logic [7:0] ld;

    int checks   = 0;
    int failures = 0;
    int cyc;
    int n;

    led_panel_scheduler #(
        .CLK_DIV_W    (4),
        .HOLD_TICKS   (2),
        .STRETCH_TICKS(2)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .mode    (mode),
        .id      (id),
        .req     (req),
        .err_code(err_code),
        .act_pat (act_pat),
        .usr_pat (usr_pat),
        .trig    (trig),
        .grant   (grant),
        .led1    (led1),
        .led2    (led2),
        .led3    (led3),
        .ld      (ld)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Clocks since reset release; equals the expected prescaler value.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        mode     = 1'b1;
        id       = 4'hA;
        req      = 3'b000;
        err_code = 8'h00;
        act_pat  = 8'h00;
        usr_pat  = 8'h00;
        trig     = 2'b00;

        #12;
        chk("rst_grant", {5'b0, grant}, 8'h00);
        chk("rst_ld", ld, 8'h00);
        chk("rst_leds", {5'b0, led1, led2, led3}, 8'h00);

        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("idle_first", ld, 8'h1A);
        chk("idle_grant", {5'b0, grant}, 8'h00);
        repeat (6) @(negedge clock);
        chk("idle_hb_low", ld, 8'h1A);
        @(negedge clock);
        chk("idle_hb_high", ld, 8'h9A);
        chk("idle_led1", {7'b0, led1}, 8'h01);

        // User claims and releases
        req     = 3'b001;
        usr_pat = 8'h5C;
        @(negedge clock);
        chk("usr_grant", {5'b0, grant}, 8'h01);
        chk("usr_ld", ld, 8'h5C);
        req = 3'b000;
        @(negedge clock);
        chk("usr_drop_grant", {5'b0, grant}, 8'h00);
        chk("usr_drop_ld", ld, 8'h9A);

        // Activity waits for user's hold to expire
        req = 3'b001;
        @(negedge clock);
        chk("usr_regrant", {5'b0, grant}, 8'h01);
        req     = 3'b011;
        act_pat = 8'h33;
        n = 0;
        @(negedge clock);
        n++;
        chk("hold_protects", {5'b0, grant}, 8'h01);
        while (grant === 3'b001 && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("rotate_grant", {5'b0, grant}, 8'h02);
        chk("rotate_ld", ld, 8'h33);
        chk("rotate_time", {7'b0, (n >= 17 && n <= 33)}, 8'h01);

        // Error preempts a fresh hold
        req      = 3'b110;
        err_code = 8'hE1;
        @(negedge clock);
        chk("err_grant", {5'b0, grant}, 8'h04);
        chk("err_ld", ld, 8'hE1);
        for (int i = 0; i < 4; i++) begin
            chk("err_blink", {7'b0, led1}, {7'b0, cyc[1]});
            @(negedge clock);
        end
        err_code = 8'h7E;
        @(negedge clock);
        chk("err_pat_live", ld, 8'h7E);
        chk("err_keeps", {5'b0, grant}, 8'h04);

        // Single trigger pulse
        trig = 2'b01;
        @(negedge clock);
        n = 1;
        chk("trig0_on", {7'b0, led2}, 8'h01);
        chk("trig0_led3_off", {7'b0, led3}, 8'h00);
        trig = 2'b00;
        while (led2 === 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("trig0_off", {7'b0, led2}, 8'h00);
        chk("trig0_time", {7'b0, (n >= 17 && n <= 33)}, 8'h01);

        // Retrigger while lit extends on-time
        trig = 2'b01;
        @(negedge clock);
        trig = 2'b00;
        repeat (19) @(negedge clock);
        trig = 2'b01;
        @(negedge clock);
        trig = 2'b00;
        repeat (13) @(negedge clock);
        chk("retrig_extends", {7'b0, led2}, 8'h01);
        n = 0;
        while (led2 === 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("retrig_off", {7'b0, led2}, 8'h00);

        // Second channel
        trig = 2'b10;
        @(negedge clock);
        chk("trig1_on", {7'b0, led3}, 8'h01);
        trig = 2'b00;

        // Asynchronous reset mid-operation
        trig = 2'b01;
        @(negedge clock);
        trig = 2'b00;
        @(negedge clock);
        chk("pre_rst_led2", {7'b0, led2}, 8'h01);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_grant", {5'b0, grant}, 8'h00);
        chk("arst_ld", ld, 8'h00);
        chk("arst_leds", {5'b0, led1, led2, led3}, 8'h00);
        req = 3'b000;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_rst_ld", ld, 8'h1A);
        chk("post_rst_grant", {5'b0, grant}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
